qlearn_episode_ctrl: RTL and testbench

Sequencer that drives the 4-stage Q-update pipeline. It generates one action per cycle with epsilon-greedy selection, mirrors the 8x8 grid state walk, and counts steps and episodes. It stalls issue on in-flight (state,action) read-after-write hazards, drains the pipeline at each episode end, and signals completion to the host. It sits between host/config logic and the pipeline's action input.

---
 rtl/qlearn_pkg.sv | 31 +++
 rtl/qlearn_lfsr16.sv | 16 +
 rtl/qlearn_episode_ctrl.sv | 145 ++++++++++++++
 tb/tb_qlearn_episode_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// qlearn_pkg: shared action encodings, controller states, shadow entry type and grid move rule
package qlearn_pkg;
    localparam int GRID_BITS = 3;
    localparam int STATE_W = 2 * GRID_BITS;
    localparam logic [1:0] ACT_LEFT = 2'b00;
    localparam logic [1:0] ACT_UP = 2'b01;
    localparam logic [1:0] ACT_RIGHT = 2'b10;
    localparam logic [1:0] ACT_DOWN = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_EP_END, S_FIN} ctrl_state_e;
    typedef struct packed {
        logic v;
        logic [STATE_W-1:0] s;
        logic [1:0] a;
    } sa_pair_t;
    function automatic logic [STATE_W-1:0] grid_step(input logic [STATE_W-1:0] s, input logic [1:0] a);
        logic [GRID_BITS-1:0] x;
        logic [GRID_BITS-1:0] y;
        x = s[STATE_W-1:GRID_BITS];
        y = s[GRID_BITS-1:0];
        case (a)
            ACT_LEFT:  x = (x == '0) ? x : x - GRID_BITS'(1);
            ACT_UP:    y = (y == '0) ? y : y - GRID_BITS'(1);
            ACT_RIGHT: x = (&x) ? x : x + GRID_BITS'(1);
            default:   y = (&y) ? y : y + GRID_BITS'(1);
        endcase
        return {x, y};
    endfunction
    function automatic logic [1:0] pick_action(input logic [15:0] r, input logic [7:0] eps, input logic [1:0] greedy);
        return (r[7:0] < eps) ? r[9:8] : greedy;
    endfunction
endpackage

// File: rtl/qlearn_lfsr16.sv
// qlearn_lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) shifting left while enabled
module qlearn_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else if (en_i) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/qlearn_episode_ctrl.sv
// qlearn_episode_ctrl: epsilon-greedy action sequencer with RAW hazard stalls, episode drain and counting
module qlearn_episode_ctrl
    import qlearn_pkg::*;
#(
    parameter int                 PIPE_DEPTH  = 4,
    parameter logic [STATE_W-1:0] START_STATE = 6'd0,
    parameter logic [15:0]        LFSR_SEED   = 16'hACE1,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_episodes,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [7:0]         epsilon,
    input  logic [STATE_W-1:0] goal_state,
    input  logic [1:0]         greedy_action,
    output logic [1:0]         action,
    output logic               action_valid,
    output logic [STATE_W-1:0] cur_state,
    output logic [CNT_W-1:0]   episode_cnt,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               busy,
    output logic               done
);
    localparam int DW = $clog2(PIPE_DEPTH + 1);
    ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, max_q, max_d, ep_q, ep_d, step_q, step_d;
    logic [CNT_W-1:0] step_inc, ep_inc, max_eff;
    logic [STATE_W-1:0] goal_q, goal_d, cur_q, cur_d, nxt;
    logic [1:0] act_q, act_d, cand;
    logic vld_q, vld_d, hazard;
    logic [DW-1:0] drain_q, drain_d;
    logic [15:0] lfsr;
    // the entry whose writeback lands this cycle no longer conflicts, so only PIPE_DEPTH-1 are kept
    sa_pair_t sh_q [PIPE_DEPTH-1];
    sa_pair_t sh_d [PIPE_DEPTH-1];

    qlearn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == S_RUN),
        .lfsr_o (lfsr)
    );

    assign cand = pick_action(lfsr, epsilon, greedy_action);
    assign nxt = grid_step(cur_q, cand);
    assign step_inc = (&step_q) ? step_q : step_q + CNT_W'(1);
    assign ep_inc = (&ep_q) ? ep_q : ep_q + CNT_W'(1);
    assign max_eff = (max_q == '0) ? CNT_W'(1) : max_q;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH - 1; i++)
            hazard = hazard | (sh_q[i].v && sh_q[i].s == cur_q && sh_q[i].a == cand);
    end

    always_comb begin
        state_d = state_q;
        num_d = num_q;
        max_d = max_q;
        goal_d = goal_q;
        act_d = act_q;
        vld_d = 1'b0;
        cur_d = cur_q;
        ep_d = ep_q;
        step_d = step_q;
        drain_d = drain_q;
        sh_d[0] = '0;
        for (int i = 1; i < PIPE_DEPTH - 1; i++) sh_d[i] = sh_q[i-1];
        case (state_q)
            S_IDLE: if (start) begin
                num_d = num_episodes;
                max_d = max_steps;
                goal_d = goal_state;
                ep_d = '0;
                step_d = '0;
                cur_d = START_STATE;
                sh_d = '{default: '0};
                state_d = (num_episodes == '0) ? S_FIN : S_RUN;
            end
            S_RUN: begin
                vld_d = !hazard;
                sh_d[0] = '{v: !hazard, s: cur_q, a: cand};
                if (!hazard) begin
                    act_d = cand;
                    cur_d = nxt;
                    step_d = step_inc;
                    if (nxt == goal_q || step_inc == max_eff) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(PIPE_DEPTH - 1);
                    end
                end
            end
            S_DRAIN: begin
                drain_d = (drain_q == '0) ? drain_q : drain_q - DW'(1);
                state_d = (drain_q == '0) ? S_EP_END : S_DRAIN;
            end
            S_EP_END: begin
                ep_d = ep_inc;
                cur_d = START_STATE;
                step_d = '0;
                sh_d = '{default: '0};
                state_d = (ep_inc == num_q) ? S_FIN : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q <= '0;
            max_q <= '0;
            goal_q <= '0;
            act_q <= '0;
            vld_q <= 1'b0;
            cur_q <= START_STATE;
            ep_q <= '0;
            step_q <= '0;
            drain_q <= '0;
            sh_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            num_q <= num_d;
            max_q <= max_d;
            goal_q <= goal_d;
            act_q <= act_d;
            vld_q <= vld_d;
            cur_q <= cur_d;
            ep_q <= ep_d;
            step_q <= step_d;
            drain_q <= drain_d;
            sh_q <= sh_d;
        end
    end

    assign action = act_q;
    assign action_valid = vld_q;
    assign cur_state = cur_q;
    assign episode_cnt = ep_q;
    assign step_cnt = step_q;
    assign busy = state_q != S_IDLE;
    assign done = state_q == S_FIN;
endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// tb_qlearn_episode_ctrl: directed and randomized runs checked cycle by cycle against a behavioural episode model
module tb_qlearn_episode_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_episodes = '0;
    logic [15:0] max_steps = '0;
    logic [7:0]  epsilon = '0;
    logic [5:0]  goal_state = '0;
    logic [1:0]  greedy_action = '0;
    logic [1:0]  action;
    logic        action_valid;
    logic [5:0]  cur_state;
    logic [15:0] episode_cnt;
    logic [15:0] step_cnt;
    logic        busy;
    logic        done;

    int passed = 0;
    int failed = 0;
    int total = 0;

    typedef struct {
        bit       v;
        bit [1:0] a;
        bit [5:0] s;
        int       st;
        int       ep;
        bit       d;
        bit       b;
    } exp_t;
    exp_t ex[$];
    bit [1:0] g_arr[$];
    bit [15:0] m_lfsr;

    always #5 clk = ~clk;

    qlearn_episode_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_episodes  (num_episodes),
        .max_steps     (max_steps),
        .epsilon       (epsilon),
        .goal_state    (goal_state),
        .greedy_action (greedy_action),
        .action        (action),
        .action_valid  (action_valid),
        .cur_state     (cur_state),
        .episode_cnt   (episode_cnt),
        .step_cnt      (step_cnt),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".action"}, 32'(action), 0);
        chk({tag, ".valid"}, 32'(action_valid), 0);
        chk({tag, ".cur_state"}, 32'(cur_state), 0);
        chk({tag, ".episode_cnt"}, 32'(episode_cnt), 0);
        chk({tag, ".step_cnt"}, 32'(step_cnt), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    function automatic bit [5:0] mv(input bit [5:0] s, input bit [1:0] a);
        int x;
        int y;
        x = int'(s) / 8;
        y = int'(s) % 8;
        case (a)
            2'd0: x = (x > 0) ? x - 1 : x;
            2'd1: y = (y > 0) ? y - 1 : y;
            2'd2: x = (x < 7) ? x + 1 : x;
            default: y = (y < 7) ? y + 1 : y;
        endcase
        return 6'(x * 8 + y);
    endfunction

    function automatic bit [15:0] lfsr_nx(input bit [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // expected output after every clock edge from the start edge until the block is idle again
    task automatic build(input int num, input int maxs, input int eps, input bit [5:0] goal, input int gmode);
        int cap;
        int hist[$];
        int code;
        bit [5:0] s;
        int st;
        bit fin;
        bit hz;
        bit [1:0] g;
        bit [1:0] c;
        cap = (maxs == 0) ? 1 : maxs;
        ex.delete();
        g_arr.delete();
        g_arr.push_back(2'd0);
        ex.push_back('{1'b0, 2'd0, 6'd0, 0, 0, num == 0, 1'b1});
        for (int e = 0; e < num; e++) begin
            s = 6'd0;
            st = 0;
            fin = 1'b0;
            hist.delete();
            while (!fin) begin
                g = (gmode < 4) ? 2'(gmode) : 2'($urandom_range(3));
                c = (int'(m_lfsr[7:0]) < eps) ? m_lfsr[9:8] : g;
                code = int'(s) * 4 + int'(c);
                hz = 1'b0;
                foreach (hist[i]) if (hist[i] == code) hz = 1'b1;
                hist.push_back(hz ? -1 : code);
                if (hist.size() > 3) void'(hist.pop_front());
                m_lfsr = lfsr_nx(m_lfsr);
                if (!hz) begin
                    s = mv(s, c);
                    st++;
                    fin = (s == goal) || (st == cap);
                end
                g_arr.push_back(g);
                ex.push_back('{!hz, c, s, st, e, 1'b0, 1'b1});
            end
            repeat (4) begin
                g_arr.push_back(2'($urandom_range(3)));
                ex.push_back('{1'b0, 2'd0, s, st, e, 1'b0, 1'b1});
            end
            g_arr.push_back(2'($urandom_range(3)));
            ex.push_back('{1'b0, 2'd0, 6'd0, 0, e + 1, (e + 1) == num, 1'b1});
        end
        g_arr.push_back(2'd0);
        ex.push_back('{1'b0, 2'd0, 6'd0, 0, num, 1'b0, 1'b0});
    endtask

    task automatic run(input string tag, input int num, input int maxs, input int eps,
                       input bit [5:0] goal, input int gmode, input int poke);
        build(num, maxs, eps, goal, gmode);
        @(negedge clk);
        num_episodes = 16'(num);
        max_steps = 16'(maxs);
        epsilon = 8'(eps);
        goal_state = goal;
        greedy_action = g_arr[0];
        start = 1'b1;
        for (int n = 0; n < ex.size(); n++) begin
            if (n > 0) begin
                @(negedge clk);
                start = (n == poke);
                if (n == poke) begin
                    num_episodes = 16'($urandom_range(1, 9));
                    max_steps = 16'($urandom_range(1, 9));
                    goal_state = 6'($urandom_range(63));
                end
                greedy_action = g_arr[n];
            end
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].valid", tag, n), 32'(action_valid), 32'(ex[n].v));
            if (ex[n].v) chk($sformatf("%s[%0d].action", tag, n), 32'(action), 32'(ex[n].a));
            chk($sformatf("%s[%0d].cur_state", tag, n), 32'(cur_state), 32'(ex[n].s));
            chk($sformatf("%s[%0d].step_cnt", tag, n), 32'(step_cnt), 32'(ex[n].st));
            chk($sformatf("%s[%0d].episode_cnt", tag, n), 32'(episode_cnt), 32'(ex[n].ep));
            chk($sformatf("%s[%0d].done", tag, n), 32'(done), 32'(ex[n].d));
            chk($sformatf("%s[%0d].busy", tag, n), 32'(busy), 32'(ex[n].b));
        end
        start = 1'b0;
    endtask

    initial begin
        m_lfsr = 16'hACE1;
        #1;
        chk_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run("basic", 1, 3, 0, 6'o77, 2, -1);
        run("wall_hazard", 1, 4, 0, 6'o77, 0, -1);
        run("goal", 1, 100, 0, 6'd1, 3, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        run("explore", 1, 24, 255, 6'o77, 4, -1);
        run("multi", 3, 2, 100, 6'o77, 4, 3);
        for (int k = 0; k < 4; k++)
            run($sformatf("rand%0d", k), $urandom_range(1, 3), $urandom_range(0, 8),
                $urandom_range(255), 6'($urandom_range(63)), 4, $urandom_range(2, 4));
        @(negedge clk);
        num_episodes = 16'd2;
        max_steps = 16'd50;
        epsilon = 8'd0;
        goal_state = 6'o77;
        greedy_action = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        run("zero_eps", 0, 5, 0, 6'd0, 0, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
